// File: rtl/dispatch_deserializer_pkg.sv
// Dispatch word geometry shared by the source stage and its byte-stream front end.
package dispatch_deserializer_pkg;

    localparam int SRC_WIDTH = 20;

    function automatic int bytes_for_width(input int width);
        return (width + 7) / 8;
    endfunction

    localparam int SRC_BYTES = bytes_for_width(SRC_WIDTH);

endpackage

// File: rtl/dispatch_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word that
// holds its last value while empty.
module dispatch_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    rd_next_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic [WIDTH-1:0] dout_r;
    logic [WIDTH-1:0] dout_next_s;
    logic             push_s;
    logic             pop_s;

    // Next occupancy, read pointer and head word.
    always_comb begin
        push_s       = push && (count_r != CW'(DEPTH));
        pop_s        = pop && (count_r != CW'(0));
        rd_next_s    = pop_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
        dout_next_s = dout_r;
        if (count_next_s == CW'(0)) begin
            dout_next_s = dout_r;
        end else if (push_s && ((count_r - (pop_s ? CW'(1) : CW'(0))) == CW'(0))) begin
            // The word being written becomes the head immediately.
            dout_next_s = din;
        end else begin
            dout_next_s = mem_r[rd_next_s];
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy and head register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
            dout_r   <= WIDTH'(0);
        end else begin
            wr_ptr_r <= push_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
            rd_ptr_r <= rd_next_s;
            count_r  <= count_next_s;
            dout_r   <= dout_next_s;
        end
    end

    assign dout  = dout_r;
    assign empty = (count_r == CW'(0));
    assign full  = (count_r == CW'(DEPTH));

endmodule

// File: rtl/dispatch_deserializer.sv
// Packs MSB-first host bytes into dispatch words and queues them for the
// source stage, optionally dropping partial words that stall too long.
module dispatch_deserializer
    import dispatch_deserializer_pkg::*;
#(
    parameter int SRC_WIDTH      = dispatch_deserializer_pkg::SRC_WIDTH,
    parameter int OUT_DEPTH      = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    input  logic [7:0]           rx_data,
    output logic                 src_valid,
    input  logic                 src_ready,
    output logic [SRC_WIDTH-1:0] src,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int NBYTES = bytes_for_width(SRC_WIDTH);
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam int TO_W  = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    logic [IDX_W-1:0]     byte_idx_r;
    logic [SRC_WIDTH-1:0] shreg_r;
    logic [TO_W-1:0]      to_cnt_r;
    logic                 frame_err_r;
    logic                 last_s;
    logic                 rx_ready_s;
    logic                 accept_s;
    logic                 push_s;
    logic                 expire_s;
    logic [SRC_WIDTH-1:0] word_s;
    logic                 fifo_empty_s;
    logic                 fifo_full_s;

    // Handshake decode and word assembly; pad bits of the first byte fall off the top.
    always_comb begin
        last_s     = (byte_idx_r == LAST_IDX);
        rx_ready_s = !last_s || !fifo_full_s;
        accept_s   = rx_valid && rx_ready_s;
        push_s     = accept_s && last_s;
        word_s     = SRC_WIDTH'({shreg_r, rx_data});
        expire_s   = TO_EN && (byte_idx_r != IDX_W'(0)) && !accept_s && (to_cnt_r == TO_LAST);
    end

    // Byte position, shift register and idle timeout; an arriving byte beats expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx_r  <= IDX_W'(0);
            shreg_r     <= SRC_WIDTH'(0);
            to_cnt_r    <= TO_W'(0);
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= expire_s;
            if (accept_s) begin
                shreg_r    <= word_s;
                byte_idx_r <= last_s ? IDX_W'(0) : byte_idx_r + IDX_W'(1);
                to_cnt_r   <= TO_W'(0);
            end else if (expire_s) begin
                byte_idx_r <= IDX_W'(0);
                shreg_r    <= SRC_WIDTH'(0);
                to_cnt_r   <= TO_W'(0);
            end else if (TO_EN && (byte_idx_r != IDX_W'(0))) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end else begin
                to_cnt_r <= TO_W'(0);
            end
        end
    end

    dispatch_fifo #(
        .WIDTH (SRC_WIDTH),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   (word_s),
        .pop   (src_ready),
        .dout  (src),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );

    assign rx_ready  = rx_ready_s;
    assign src_valid = !fifo_empty_s;
    assign frame_err = frame_err_r;
    assign busy      = (byte_idx_r != IDX_W'(0)) || !fifo_empty_s;

endmodule
